// File: rtl/qpi_arb_pkg.sv
// rtl/qpi_arb_pkg.sv - shared types and constants for the QPI bus arbiter
// Purpose: arbiter state encoding, master index constants and the round-robin pick helper.
// Ports: none (package).
package qpi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2,
    GAP  = 2'd3
  } arb_state_t;

  localparam int M_FLASH = 0;
  localparam int M_ML    = 1;

  // One-hot choice among the requesters; on a tie the master that did not own
  // the bus last wins. Returns 2'b00 when nobody is requesting.
  function automatic logic [1:0] pick_master(input logic [1:0] req, input logic last);
    logic [1:0] choice;
    if (req == 2'b11) begin
      choice = last ? 2'b01 : 2'b10;
    end else begin
      choice = req;
    end
    return choice;
  endfunction

endpackage

// File: rtl/qpi_pin_mux.sv
// rtl/qpi_pin_mux.sv - registered owner select of the shared QPI pad outputs
// Purpose: drives the pads from the selected master one cycle later; idles the pads when
//          no master is selected (all csb high, clk low, outputs disabled).
// Ports:
//   clk, resetn            clock, asynchronous active-low reset (pads idle in reset)
//   sel[1:0]               one-hot owner for the coming cycle, 2'b00 = idle
//   m_csb/m_clk[1:0]       master chip selects / serial clocks
//   m_do/m_oe[7:0]         master data / enables, [3:0]=M0, [7:4]=M1
//   pad_csb[1:0]           [0]=flash_csb, [1]=ml_csb
//   pad_clk, pad_do, pad_oe  shared QPI pins
module qpi_pin_mux
  import qpi_arb_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] sel,
  input  logic [1:0] m_csb,
  input  logic [1:0] m_clk,
  input  logic [7:0] m_do,
  input  logic [7:0] m_oe,
  output logic       pad_clk,
  output logic [1:0] pad_csb,
  output logic [3:0] pad_do,
  output logic [3:0] pad_oe
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pad_csb <= 2'b11;
      pad_clk <= 1'b0;
      pad_do  <= 4'h0;
      pad_oe  <= 4'h0;
    end else if (sel[M_FLASH]) begin
      pad_csb <= {1'b1, m_csb[M_FLASH]};
      pad_clk <= m_clk[M_FLASH];
      pad_do  <= m_do[3:0];
      pad_oe  <= m_oe[3:0];
    end else if (sel[M_ML]) begin
      pad_csb <= {m_csb[M_ML], 1'b1};
      pad_clk <= m_clk[M_ML];
      pad_do  <= m_do[7:4];
      pad_oe  <= m_oe[7:4];
    end else begin
      pad_csb <= 2'b11;
      pad_clk <= 1'b0;
      pad_do  <= 4'h0;
      pad_oe  <= 4'h0;
    end
  end

endmodule

// File: rtl/qpi_bus_arbiter.sv
// rtl/qpi_bus_arbiter.sv - round-robin sharing of one QPI pin set between flash XIP and ML masters
// Purpose: grants the bus, routes the owner's pins through qpi_pin_mux and inserts a
//          CS_GAP-cycle idle gap on every handover.
// Optional feature macro: QPI_ARB_TIMEOUT_EN (forced revoke after MAX_HOLD owned cycles).
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   m_req[1:0]             bus requests, [0]=flash, [1]=ML
//   m_gnt[1:0]             registered one-hot grant
//   m_csb/m_clk[1:0]       master chip selects / serial clocks
//   m_do/m_oe[7:0]         master data / enables, [3:0]=M0, [7:4]=M1
//   m_di[3:0]              pad input data to both masters (combinational)
//   pad_clk/pad_csb/pad_do/pad_oe  registered pad outputs
//   pad_di[3:0]            pad input data
//   arb_timeout            one-cycle pulse on forced revoke
module qpi_bus_arbiter
  import qpi_arb_pkg::*;
#(
  parameter int CS_GAP   = 2,
  parameter int MAX_HOLD = 4096
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] m_req,
  output logic [1:0] m_gnt,
  input  logic [1:0] m_csb,
  input  logic [1:0] m_clk,
  input  logic [7:0] m_do,
  input  logic [7:0] m_oe,
  output logic [3:0] m_di,
  output logic       pad_clk,
  output logic [1:0] pad_csb,
  output logic [3:0] pad_do,
  output logic [3:0] pad_oe,
  input  logic [3:0] pad_di,
  output logic       arb_timeout
);

  localparam int              GAP_W    = $clog2(CS_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

  if (CS_GAP < 1 || MAX_HOLD < 1) begin : g_param_check
    $error("qpi_bus_arbiter: CS_GAP and MAX_HOLD must both be at least 1");
  end

  arb_state_t       state, state_nx;
  logic             last_q, last_nx;   // index of the master granted most recently
  logic [GAP_W-1:0] gap_cnt, gap_nx;
  logic [1:0]       pick;
  logic [1:0]       gnt_nx;
  logic             owning;
  logic             own_idx;
  logic             release_own;
  logic             revoke;
  logic             arbitrate;

  assign m_di        = pad_di;
  assign owning      = (state == OWN0) || (state == OWN1);
  assign own_idx     = (state == OWN1);
  // Dropping the request alone is not enough: the owner keeps the bus until its
  // own chip select is high, so a transaction is never cut short.
  assign release_own = !m_req[own_idx] && m_csb[own_idx];
  assign pick        = pick_master(m_req, last_q);

  always_comb begin
    state_nx  = state;
    gap_nx    = gap_cnt;
    last_nx   = last_q;
    arbitrate = 1'b0;
    unique case (state)
      IDLE: arbitrate = 1'b1;
      OWN0, OWN1: begin
        if (release_own || revoke) begin
          state_nx = GAP;
          gap_nx   = '0;
        end
      end
      GAP: begin
        // The last gap cycle doubles as the arbitration slot, so the handover
        // shows exactly CS_GAP cycles of no grant.
        if (gap_cnt == GAP_LAST) begin
          arbitrate = 1'b1;
        end else begin
          gap_nx = gap_cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (arbitrate) begin
      if (pick[M_FLASH]) begin
        state_nx = OWN0;
        last_nx  = 1'(M_FLASH);
      end else if (pick[M_ML]) begin
        state_nx = OWN1;
        last_nx  = 1'(M_ML);
      end else begin
        state_nx = IDLE;
      end
    end
  end

  assign gnt_nx = {state_nx == OWN1, state_nx == OWN0};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      last_q  <= 1'(M_ML);
      gap_cnt <= '0;
      m_gnt   <= 2'b00;
    end else begin
      state   <= state_nx;
      last_q  <= last_nx;
      gap_cnt <= gap_nx;
      m_gnt   <= gnt_nx;
    end
  end

`ifdef QPI_ARB_TIMEOUT_EN
  localparam int               HOLD_W     = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] hold_cnt;   // owned cycles already completed, saturating

  // The current owned cycle is the MAX_HOLD-th one; give way only if the other
  // master is actually waiting.
  assign revoke = (hold_cnt >= HOLD_LAST) && m_req[!own_idx];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_cnt    <= '0;
      arb_timeout <= 1'b0;
    end else begin
      arb_timeout <= owning && !release_own && revoke;
      if (arbitrate && (gnt_nx != 2'b00)) begin
        hold_cnt <= '0;
      end else if (owning && (hold_cnt != HOLD_LIMIT)) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end
`else
  assign revoke      = 1'b0;
  assign arb_timeout = 1'b0;
`endif

  qpi_pin_mux u_pin_mux (
    .clk     (clk),
    .resetn  (resetn),
    .sel     (gnt_nx),
    .m_csb   (m_csb),
    .m_clk   (m_clk),
    .m_do    (m_do),
    .m_oe    (m_oe),
    .pad_clk (pad_clk),
    .pad_csb (pad_csb),
    .pad_do  (pad_do),
    .pad_oe  (pad_oe)
  );

endmodule
